// File: rtl/vga_scan_controller.sv
// VGA raster scanner: derives 640x480@60 timing from a divided clock, generates VRAM addresses
// for a SCALE-upscaled frame buffer and registers blank-gated RGB with aligned syncs.
module vga_scan_controller #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE       = 5,
  parameter int unsigned IMG_W       = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ram_red,
  input  logic        ram_green,
  input  logic        ram_blue,
  output logic [13:0] pixel_address,
  output logic        VGA_RED,
  output logic        VGA_GREEN,
  output logic        VGA_BLUE,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic        frame_start
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
  localparam int unsigned DivW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW         = $clog2(HTotal);
  localparam int unsigned VW         = $clog2(VTotal);
  localparam int unsigned SubW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned ColW       = $clog2(IMG_W + 1);
  localparam int unsigned AddrW      = 14;

  logic [DivW-1:0]  div_q, div_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [SubW-1:0]  hsub_q, hsub_d;
  logic [SubW-1:0]  vsub_q, vsub_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [AddrW-1:0] row_base_q, row_base_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [2:0]       cap_q, cap_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             fs_q, fs_d;

  logic       tick;
  logic       h_wrap, v_wrap;
  logic       cur_active, next_active;
  logic       cap_now;
  logic [2:0] ram_rgb, src_rgb;

  assign ram_rgb = {ram_red, ram_green, ram_blue};

  always_comb begin
    div_d      = div_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hsub_d     = hsub_q;
    vsub_d     = vsub_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    cap_d      = cap_q;
    rgb_d      = rgb_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    fs_d       = 1'b0;

    tick        = (div_q == DivW'(CLK_DIV - 1));
    h_wrap      = (hcnt_q == HW'(HTotal - 1));
    v_wrap      = (vcnt_q == VW'(VTotal - 1));
    cur_active  = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    next_active = 1'b0;

    // RAM data for the address issued on the last tick is valid RAM_LATENCY clks later.
    cap_now = (div_q == DivW'(RAM_LATENCY));
    src_rgb = cap_now ? ram_rgb : cap_q;
    if (cap_now) begin
      cap_d = ram_rgb;
    end

    div_d = tick ? '0 : div_q + 1'b1;

    if (tick) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      end

      if (h_wrap) begin
        hsub_d = '0;
        col_d  = '0;
      end else if (hcnt_q < HW'(H_ACTIVE)) begin
        if (hsub_q == SubW'(SCALE - 1)) begin
          hsub_d = '0;
          col_d  = col_q + 1'b1;
        end else begin
          hsub_d = hsub_q + 1'b1;
        end
      end

      if (h_wrap) begin
        if (v_wrap) begin
          vsub_d     = '0;
          row_base_d = '0;
        end else if (vcnt_q < VW'(V_ACTIVE)) begin
          if (vsub_q == SubW'(SCALE - 1)) begin
            vsub_d     = '0;
            row_base_d = row_base_q + AddrW'(IMG_W);
          end else begin
            vsub_d = vsub_q + 1'b1;
          end
        end
      end

      next_active = (hcnt_d < HW'(H_ACTIVE)) && (vcnt_d < VW'(V_ACTIVE));
      addr_d      = next_active ? row_base_d + AddrW'(col_d) : '0;

      // Output stage presents the pixel addressed one tick earlier (the current counters).
      rgb_d   = cur_active ? src_rgb : 3'b000;
      hsync_d = ~((hcnt_q >= HW'(HSyncStart)) && (hcnt_q < HW'(HSyncEnd)));
      vsync_d = ~((vcnt_q >= VW'(VSyncStart)) && (vcnt_q < VW'(VSyncEnd)));
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hsub_q     <= '0;
      vsub_q     <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      cap_q      <= '0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fs_q       <= 1'b0;
    end else if (!enable) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hsub_q     <= '0;
      vsub_q     <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      cap_q      <= '0;
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hsub_q     <= hsub_d;
      vsub_q     <= vsub_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      cap_q      <= cap_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fs_q       <= fs_d;
    end
  end

  assign pixel_address = addr_q;
  assign VGA_RED       = rgb_q[2];
  assign VGA_GREEN     = rgb_q[1];
  assign VGA_BLUE      = rgb_q[0];
  assign VGA_HSYNC     = hsync_q;
  assign VGA_VSYNC     = vsync_q;
  assign frame_start   = fs_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: a full-size instance for line timing and addressing, and a
// shrunken-timing instance so whole frames, enable and reset restarts fit in a short run.
module tb_vga_scan_controller;

  // Shrunken timing: 28 px per line, 14 lines per frame, 20x10 active, 4x2 image.
  localparam int unsigned BHT = 28;
  localparam int unsigned BVT = 14;
  localparam int unsigned BFrameClks = BHT * BVT * 4;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int unsigned cyc;
  int errors = 0;
  int checks = 0;

  logic [13:0] a_addr, b_addr;
  logic a_red, a_green, a_blue, a_hsync, a_vsync, a_fs;
  logic b_red, b_green, b_blue, b_hsync, b_vsync, b_fs;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  vga_scan_controller u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ram_red       (a_addr[0]),
    .ram_green     (1'b1),
    .ram_blue      (a_addr[7]),
    .pixel_address (a_addr),
    .VGA_RED       (a_red),
    .VGA_GREEN     (a_green),
    .VGA_BLUE      (a_blue),
    .VGA_HSYNC     (a_hsync),
    .VGA_VSYNC     (a_vsync),
    .frame_start   (a_fs)
  );

  vga_scan_controller #(
    .CLK_DIV(4), .RAM_LATENCY(1), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1), .SCALE(5), .IMG_W(4)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .ram_red       (1'b1),
    .ram_green     (1'b1),
    .ram_blue      (1'b1),
    .pixel_address (b_addr),
    .VGA_RED       (b_red),
    .VGA_GREEN     (b_green),
    .VGA_BLUE      (b_blue),
    .VGA_HSYNC     (b_hsync),
    .VGA_VSYNC     (b_vsync),
    .frame_start   (b_fs)
  );

  function automatic logic [13:0] b_exp_addr(input int unsigned q);
    int unsigned h, v;
    h = q % BHT;
    v = q / BHT;
    if (h < 20 && v < 10) return 14'((v / 5) * 4 + h / 5);
    return 14'd0;
  endfunction

  task automatic wait_cyc(input int unsigned t);
    int unsigned k;
    k = 0;
    while (cyc < t && k < 200000) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_reset();
    checks++; if (a_addr !== 14'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", a_addr); end
    checks++; if ({a_red, a_green, a_blue} !== 3'b000) begin
      errors++; $display("FAIL rst_rgb got=%b exp=000", {a_red, a_green, a_blue}); end
    checks++; if (a_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got=%b exp=1", a_hsync); end
    checks++; if (a_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got=%b exp=1", a_vsync); end
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL rst_fs got=%b exp=0", a_fs); end
    checks++; if (b_hsync !== 1'b1) begin errors++; $display("FAIL rst_b_hsync got=%b exp=1", b_hsync); end
  endtask

  task automatic test_first_tick();
    wait_cyc(3);
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL fs_before_tick got=%b exp=0", a_fs); end
    wait_cyc(4);
    checks++; if (a_fs !== 1'b1) begin errors++; $display("FAIL fs_first_tick got=%b exp=1", a_fs); end
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL b_fs_first_tick got=%b exp=1", b_fs); end
    checks++; if (a_green !== 1'b1) begin errors++; $display("FAIL px0_green got=%b exp=1", a_green); end
    checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL px0_red got=%b exp=0", a_red); end
    wait_cyc(5);
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL fs_one_clk got=%b exp=0", a_fs); end
  endtask

  // Address of pixel p is held from clk 4p; pixel p is presented from clk 4p+4.
  task automatic test_line0();
    wait_cyc(17);
    checks++; if (a_addr !== 14'd0) begin errors++; $display("FAIL addr_px4 got=%0d exp=0", a_addr); end
    wait_cyc(21);
    checks++; if (a_addr !== 14'd1) begin errors++; $display("FAIL addr_px5 got=%0d exp=1", a_addr); end
    checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL red_px4 got=%b exp=0", a_red); end
    wait_cyc(25);
    checks++; if (a_red !== 1'b1) begin errors++; $display("FAIL red_px5 got=%b exp=1", a_red); end
    wait_cyc(41);
    checks++; if (a_red !== 1'b1) begin errors++; $display("FAIL red_px9 got=%b exp=1", a_red); end
    wait_cyc(45);
    checks++; if (a_red !== 1'b0) begin errors++; $display("FAIL red_px10 got=%b exp=0", a_red); end
    wait_cyc(2557);
    checks++; if (a_addr !== 14'd127) begin errors++; $display("FAIL addr_px639 got=%0d exp=127", a_addr); end
    wait_cyc(2561);
    checks++; if (a_addr !== 14'd0) begin errors++; $display("FAIL addr_px640 got=%0d exp=0", a_addr); end
    checks++; if ({a_red, a_green} !== 2'b11) begin
      errors++; $display("FAIL rg_px639 got=%b exp=11", {a_red, a_green}); end
    wait_cyc(2565);
    checks++; if ({a_red, a_green, a_blue} !== 3'b000) begin
      errors++; $display("FAIL rgb_blank_px640 got=%b exp=000", {a_red, a_green, a_blue}); end
  endtask

  task automatic test_hsync();
    int unsigned k;
    k = 0;
    while (a_hsync !== 1'b0 && k < 4000) begin @(posedge clk); #1; k++; end
    checks++; if (cyc !== 2628) begin errors++; $display("FAIL hsync_fall got=%0d exp=2628", cyc); end
    k = 0;
    while (a_hsync !== 1'b1 && k < 4000) begin @(posedge clk); #1; k++; end
    checks++; if (cyc !== 3012) begin errors++; $display("FAIL hsync_rise got=%0d exp=3012", cyc); end
    wait_cyc(5827);
    checks++; if (a_hsync !== 1'b1) begin errors++; $display("FAIL hsync_pre2 got=%b exp=1", a_hsync); end
    wait_cyc(5828);
    checks++; if (a_hsync !== 1'b0) begin errors++; $display("FAIL hsync_fall2 got=%b exp=0", a_hsync); end
  endtask

  task automatic test_rows();
    wait_cyc(9621);
    checks++; if (a_addr !== 14'd1) begin errors++; $display("FAIL addr_l3_px5 got=%0d exp=1", a_addr); end
    wait_cyc(15357);
    checks++; if (a_addr !== 14'd127) begin errors++; $display("FAIL addr_l4_px639 got=%0d exp=127", a_addr); end
    wait_cyc(15360);
    checks++; if (a_blue !== 1'b0) begin errors++; $display("FAIL blue_l4 got=%b exp=0", a_blue); end
    wait_cyc(16001);
    checks++; if (a_addr !== 14'd128) begin errors++; $display("FAIL addr_l5_px0 got=%0d exp=128", a_addr); end
    wait_cyc(16004);
    checks++; if (a_blue !== 1'b1) begin errors++; $display("FAIL blue_l5 got=%b exp=1", a_blue); end
    wait_cyc(16029);
    checks++; if (a_addr !== 14'd129) begin errors++; $display("FAIL addr_l5_px7 got=%0d exp=129", a_addr); end
  endtask

  // Walks one whole frame of the shrunken instance clock by clock against a timing model.
  task automatic test_b_frame(output int unsigned e2);
    int unsigned k, e, p, h, v, pulses, vs_low;
    logic act, hs, vs;
    k = 0;
    while (b_fs !== 1'b1 && k < 2000) begin @(posedge clk); #1; k++; end
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL b_fs_found got=%b exp=1", b_fs); end
    e = cyc;
    pulses = 0;
    vs_low = 0;
    for (int i = 0; i < int'(BFrameClks); i++) begin
      wait_cyc(e + i);
      p = i / 4;
      h = p % BHT;
      v = p / BHT;
      act = (h < 20) && (v < 10);
      hs = !(h >= 22 && h < 25);
      vs = !(v >= 11 && v < 13);
      if (b_fs === 1'b1) pulses++;
      if (b_vsync === 1'b0) vs_low++;
      checks++; if ({b_red, b_green, b_blue} !== {3{act}}) begin errors++;
        $display("FAIL b_rgb i=%0d got=%b exp=%b", i, {b_red, b_green, b_blue}, {3{act}}); end
      checks++; if (b_hsync !== hs) begin errors++;
        $display("FAIL b_hsync i=%0d got=%b exp=%b", i, b_hsync, hs); end
      checks++; if (b_vsync !== vs) begin errors++;
        $display("FAIL b_vsync i=%0d got=%b exp=%b", i, b_vsync, vs); end
      checks++; if (b_addr !== b_exp_addr((p + 1) % (BHT * BVT))) begin errors++;
        $display("FAIL b_addr i=%0d got=%0d exp=%0d", i, b_addr, b_exp_addr((p + 1) % (BHT * BVT))); end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL b_fs_count got=%0d exp=1", pulses); end
    checks++; if (vs_low !== 224) begin errors++; $display("FAIL b_vsync_len got=%0d exp=224", vs_low); end
    e2 = e + BFrameClks;
    wait_cyc(e2);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL b_fs_period got=%b exp=1", b_fs); end
  endtask

  task automatic test_enable(input int unsigned e2, output int unsigned r2);
    int unsigned r;
    wait_cyc(e2 + 88);
    checks++; if (b_hsync !== 1'b0) begin errors++; $display("FAIL en_pre_hsync got=%b exp=0", b_hsync); end
    enable = 1'b0;
    wait_cyc(e2 + 89);
    checks++; if (b_hsync !== 1'b1) begin errors++; $display("FAIL en_off_hsync got=%b exp=1", b_hsync); end
    wait_cyc(e2 + 95);
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL en_off_fs got=%b exp=0", b_fs); end
    enable = 1'b1;
    r = e2 + 95;
    wait_cyc(r + 3);
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL reen_fs_early got=%b exp=0", b_fs); end
    wait_cyc(r + 4);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL reen_fs got=%b exp=1", b_fs); end
    checks++; if (b_red !== 1'b1) begin errors++; $display("FAIL reen_red got=%b exp=1", b_red); end
    wait_cyc(r + 28);
    checks++; if (b_addr !== 14'd1) begin errors++; $display("FAIL reen_addr got=%0d exp=1", b_addr); end
    enable = 1'b0;
    wait_cyc(r + 29);
    checks++; if (b_red !== 1'b0) begin errors++; $display("FAIL en_off_red got=%b exp=0", b_red); end
    checks++; if (b_addr !== 14'd0) begin errors++; $display("FAIL en_off_addr got=%0d exp=0", b_addr); end
    wait_cyc(r + 40);
    enable = 1'b1;
    r2 = r + 40;
    wait_cyc(r2 + 4);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL reen2_fs got=%b exp=1", b_fs); end
  endtask

  task automatic test_reset_mid(input int unsigned r2);
    wait_cyc(r2 + 2630);
    checks++; if (a_hsync !== 1'b0) begin errors++; $display("FAIL mid_pre_hsync got=%b exp=0", a_hsync); end
    checks++; if (b_red !== 1'b1) begin errors++; $display("FAIL mid_pre_red got=%b exp=1", b_red); end
    checks++; if (b_addr !== 14'd6) begin errors++; $display("FAIL mid_pre_addr got=%0d exp=6", b_addr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (a_hsync !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync got=%b exp=1", a_hsync); end
    checks++; if (b_red !== 1'b0) begin errors++; $display("FAIL mid_rst_red got=%b exp=0", b_red); end
    checks++; if (b_addr !== 14'd0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", b_addr); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_cyc(3);
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL mid_fs_early got=%b exp=0", a_fs); end
    wait_cyc(4);
    checks++; if (a_fs !== 1'b1) begin errors++; $display("FAIL mid_fs got=%b exp=1", a_fs); end
  endtask

  initial begin
    int unsigned e2, r2;
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_first_tick();
    test_line0();
    test_hsync();
    test_rows();
    test_b_frame(e2);
    test_enable(e2, r2);
    test_reset_mid(r2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
